// File: rtl/alarm_pkg.sv
// Shared alarm-system types and default tuning constants for the laser trip detector.
package alarm_pkg;

  typedef enum logic [1:0] {
    SYS_DISARMED = 2'd0,
    SYS_ARMING   = 2'd1,
    SYS_ARMED    = 2'd2,
    SYS_ALARM    = 2'd3
  } alarm_sys_state_t;

  typedef enum logic [2:0] {
    LD_IDLE      = 3'd0,
    LD_CALIBRATE = 3'd1,
    LD_MONITOR   = 3'd2,
    LD_TRIPPED   = 3'd3,
    LD_FAULT     = 3'd4
  } laser_det_state_t;

  localparam int unsigned LD_SAMPLE_W     = 12;
  localparam int unsigned LD_CAL_LOG2     = 4;
  localparam int unsigned LD_DROP_MARGIN  = 400;
  localparam int unsigned LD_DEBOUNCE_N   = 8;
  localparam int unsigned LD_MIN_BASELINE = 1000;

endpackage

// File: rtl/laser_trip_detector_if.sv
// Control, sample and status bundle between the ADC front end / system FSM and the detector.
interface laser_trip_detector_if #(
  parameter int unsigned SAMPLE_W = 12
);
  logic                arm;
  logic                disarm;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic                laser_triggered;
  logic                ready;
  logic                no_beam_fault;
  logic [SAMPLE_W-1:0] baseline;

  modport master (
    output arm, disarm, sample_valid, sample,
    input  laser_triggered, ready, no_beam_fault, baseline
  );

  modport slave (
    input  arm, disarm, sample_valid, sample,
    output laser_triggered, ready, no_beam_fault, baseline
  );
endinterface

// File: rtl/beam_calibrator.sv
// Averages 2^CAL_LOG2 valid samples into a beam baseline and derives the break threshold.
module beam_calibrator
  import alarm_pkg::*;
#(
  parameter int unsigned SAMPLE_W     = LD_SAMPLE_W,
  parameter int unsigned CAL_LOG2     = LD_CAL_LOG2,
  parameter int unsigned DROP_MARGIN  = LD_DROP_MARGIN,
  parameter int unsigned MIN_BASELINE = LD_MIN_BASELINE
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                done_c,
  output logic                low_c,
  output logic [SAMPLE_W-1:0] baseline,
  output logic [SAMPLE_W-1:0] threshold
);

  localparam int unsigned ACC_W = SAMPLE_W + CAL_LOG2;

  logic [ACC_W-1:0]    acc_q, acc_d, sum_c;
  logic [CAL_LOG2-1:0] cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] baseline_q, baseline_d;
  logic [SAMPLE_W-1:0] threshold_q, threshold_d;
  logic [SAMPLE_W-1:0] avg_c;

  // Average includes the final sample so the baseline lands on the same edge as done.
  always_comb begin
    sum_c       = acc_q + ACC_W'(sample);
    avg_c       = SAMPLE_W'(sum_c >> CAL_LOG2);
    done_c      = en && (cnt_q == '1);
    low_c       = avg_c < SAMPLE_W'(MIN_BASELINE);
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    baseline_d  = baseline_q;
    threshold_d = threshold_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (done_c) begin
      acc_d       = '0;
      cnt_d       = '0;
      baseline_d  = avg_c;
      threshold_d = avg_c - SAMPLE_W'(DROP_MARGIN);
    end else if (en) begin
      acc_d = sum_c;
      cnt_d = cnt_q + CAL_LOG2'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      baseline_q  <= '0;
      threshold_q <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      baseline_q  <= baseline_d;
      threshold_q <= threshold_d;
    end
  end

  assign baseline  = baseline_q;
  assign threshold = threshold_q;

endmodule

// File: rtl/laser_trip_detector.sv
// Arms, calibrates and debounces the laser beam into a latched trip / no-beam fault indication.
module laser_trip_detector
  import alarm_pkg::*;
#(
  parameter int unsigned SAMPLE_W     = LD_SAMPLE_W,
  parameter int unsigned CAL_LOG2     = LD_CAL_LOG2,
  parameter int unsigned DROP_MARGIN  = LD_DROP_MARGIN,
  parameter int unsigned DEBOUNCE_N   = LD_DEBOUNCE_N,
  parameter int unsigned MIN_BASELINE = LD_MIN_BASELINE
) (
  input  logic                  clock,
  input  logic                  rst,
  laser_trip_detector_if.slave  bus
);

  laser_det_state_t    state_q, state_d;
  logic [7:0]          dbc_q, dbc_d;
  logic [8:0]          dbc_inc_c;
  logic                trig_q, trig_d;
  logic                ready_q, ready_d;
  logic                fault_q, fault_d;
  logic                cal_en_c, cal_clr_c;
  logic                cal_done_c, cal_low_c;
  logic [SAMPLE_W-1:0] threshold;
  logic [SAMPLE_W-1:0] baseline;

  // Calibrator is held clear outside CALIBRATE so each arm starts from zero.
  assign cal_en_c  = (state_q == LD_CALIBRATE) && bus.sample_valid && !bus.disarm;
  assign cal_clr_c = (state_q != LD_CALIBRATE) || bus.disarm;

  beam_calibrator #(
    .SAMPLE_W     (SAMPLE_W),
    .CAL_LOG2     (CAL_LOG2),
    .DROP_MARGIN  (DROP_MARGIN),
    .MIN_BASELINE (MIN_BASELINE)
  ) u_cal (
    .clock     (clock),
    .rst       (rst),
    .clr       (cal_clr_c),
    .en        (cal_en_c),
    .sample    (bus.sample),
    .done_c    (cal_done_c),
    .low_c     (cal_low_c),
    .baseline  (baseline),
    .threshold (threshold)
  );

  always_comb begin
    state_d   = state_q;
    dbc_d     = dbc_q;
    dbc_inc_c = {1'b0, dbc_q} + 9'd1;
    unique case (state_q)
      LD_IDLE: begin
        if (bus.arm) state_d = LD_CALIBRATE;
      end
      LD_CALIBRATE: begin
        if (cal_done_c) state_d = cal_low_c ? LD_FAULT : LD_MONITOR;
      end
      LD_MONITOR: begin
        if (bus.sample_valid) begin
          if (bus.sample < threshold) begin
            if (dbc_inc_c == 9'(DEBOUNCE_N)) begin
              state_d = LD_TRIPPED;
              dbc_d   = '0;
            end else begin
              dbc_d = dbc_inc_c[7:0];
            end
          end else begin
            dbc_d = '0;
          end
        end
      end
      LD_TRIPPED, LD_FAULT: ;
      default: state_d = LD_IDLE;
    endcase
    if (bus.disarm) begin
      state_d = LD_IDLE;
      dbc_d   = '0;
    end
    // Outputs decoded from the next state so they are registered yet track state exactly.
    trig_d  = (state_d == LD_TRIPPED) || (state_d == LD_FAULT);
    ready_d = (state_d == LD_MONITOR);
    fault_d = (state_d == LD_FAULT);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= LD_IDLE;
      dbc_q   <= '0;
      trig_q  <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dbc_q   <= dbc_d;
      trig_q  <= trig_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  assign bus.laser_triggered = trig_q;
  assign bus.ready           = ready_q;
  assign bus.no_beam_fault   = fault_q;
  assign bus.baseline        = baseline;

endmodule

// File: tb/tb_laser_trip_detector.sv
// Directed test-plan scenarios plus randomized traffic checked every cycle against a behavioural model.
module tb_laser_trip_detector;

  localparam int unsigned SW     = 12;
  localparam int          N_CAL  = 16;
  localparam int          MARGIN = 400;
  localparam int          DEB    = 8;
  localparam int          MINB   = 1000;

  localparam int M_IDLE = 0, M_CAL = 1, M_MON = 2, M_TRIP = 3, M_FAULT = 4;

  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  laser_trip_detector_if #(.SAMPLE_W(SW)) bus ();

  laser_trip_detector #(
    .SAMPLE_W     (SW),
    .CAL_LOG2     (4),
    .DROP_MARGIN  (400),
    .DEBOUNCE_N   (8),
    .MIN_BASELINE (1000)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: phase, collected calibration samples and current low-sample run.
  int m_ph   = M_IDLE;
  int cal_q[$];
  int m_run  = 0;
  int m_base = 0;
  int m_thr  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic a, input logic d,
                              input logic v, input int s);
    int sum;
    if (r) begin
      m_ph = M_IDLE; cal_q.delete(); m_run = 0; m_base = 0; m_thr = 0;
    end else if (d) begin
      m_ph = M_IDLE; cal_q.delete(); m_run = 0;
    end else begin
      case (m_ph)
        M_IDLE: if (a) begin m_ph = M_CAL; cal_q.delete(); end
        M_CAL: if (v) begin
          cal_q.push_back(s);
          if (cal_q.size() == N_CAL) begin
            sum = 0;
            foreach (cal_q[i]) sum += cal_q[i];
            m_base = sum / N_CAL;
            m_thr  = m_base - MARGIN;
            m_ph   = (m_base < MINB) ? M_FAULT : M_MON;
            m_run  = 0;
            cal_q.delete();
          end
        end
        M_MON: if (v) begin
          if (s < m_thr) begin
            m_run++;
            if (m_run >= DEB) begin m_ph = M_TRIP; m_run = 0; end
          end else begin
            m_run = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic a, input logic d,
                      input logic v, input int s);
    rst              = r;
    bus.arm          = a;
    bus.disarm       = d;
    bus.sample_valid = v;
    bus.sample       = SW'(s);
    @(posedge clock);
    model_update(r, a, d, v, s);
    #1;
    check_eq("trig",  32'(bus.laser_triggered), 32'((m_ph == M_TRIP) || (m_ph == M_FAULT)));
    check_eq("ready", 32'(bus.ready),           32'(m_ph == M_MON));
    check_eq("fault", 32'(bus.no_beam_fault),   32'(m_ph == M_FAULT));
    check_eq("base",  32'(bus.baseline),        32'(m_base));
  endtask

  task automatic idle_cycle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic feed(input int n, input int s);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, s);
  endtask

  int level;
  int lo, hi, smp;
  logic r_rst, r_arm, r_dis, r_val;

  initial begin
    rst = 1'b1; bus.arm = 1'b0; bus.disarm = 1'b0; bus.sample_valid = 1'b0; bus.sample = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check_eq("rst_trig", 32'(bus.laser_triggered), 0);
    check_eq("rst_base", 32'(bus.baseline), 0);

    // Nominal calibration at 3000
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    feed(15, 3000);
    check_eq("cal_not_ready_15", 32'(bus.ready), 0);
    feed(1, 3000);
    check_eq("cal_base_3000", 32'(bus.baseline), 3000);
    check_eq("cal_ready", 32'(bus.ready), 1);
    check_eq("cal_trig0", 32'(bus.laser_triggered), 0);

    // Debounce: threshold 2600 is not low; run restarts
    feed(7, 2599);
    feed(1, 2600);
    feed(7, 2599);
    check_eq("no_trip_7", 32'(bus.laser_triggered), 0);
    feed(1, 2599);
    check_eq("trip_8th", 32'(bus.laser_triggered), 1);

    // Latched trip survives light and arm
    feed(5, 4000);
    step(1'b0, 1'b1, 1'b0, 1'b1, 4000);
    check_eq("trip_latched", 32'(bus.laser_triggered), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    check_eq("trip_disarm", 32'(bus.laser_triggered), 0);
    check_eq("disarm_keep_base", 32'(bus.baseline), 3000);

    // Blocked beam fault
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    feed(16, 900);
    check_eq("fault_flag", 32'(bus.no_beam_fault), 1);
    check_eq("fault_trig", 32'(bus.laser_triggered), 1);
    check_eq("fault_ready", 32'(bus.ready), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    check_eq("fault_clear", 32'(bus.no_beam_fault), 0);
    check_eq("fault_base900", 32'(bus.baseline), 900);

    // arm+disarm together stays idle: later samples must not calibrate
    step(1'b0, 1'b1, 1'b1, 1'b0, 0);
    feed(16, 3000);
    check_eq("armdis_idle", 32'(bus.baseline), 900);

    // rst mid-calibration discards progress
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    feed(10, 2500);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    feed(16, 2000);
    check_eq("rst_recal_2000", 32'(bus.baseline), 2000);

    // Truncating average with valid gaps
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, (i % 2 == 0) ? 3001 : 3000);
      if (i < 15) idle_cycle();
    end
    check_eq("trunc_3000", 32'(bus.baseline), 3000);
    check_eq("trunc_ready", 32'(bus.ready), 1);

    // Randomized traffic
    level = 3000;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 4))
          0: level = 700;
          1: level = 1500;
          2: level = 2600;
          3: level = 3200;
          default: level = 3900;
        endcase
      end
      lo = (level > 300) ? level - 300 : 0;
      hi = (level + 150 > 4095) ? 4095 : level + 150;
      smp = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4095))
                                         : int'($urandom_range(lo, hi));
      r_rst = ($urandom_range(0, 499) == 0);
      r_dis = ($urandom_range(0, 149) == 0);
      r_arm = ($urandom_range(0, 19) == 0);
      r_val = ($urandom_range(0, 3) != 0);
      step(r_rst, r_arm, r_dis, r_val, smp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
